// File: rtl/mdu_hilo_unit.sv
// ---------------------------------------------------------------------------
// mdu_hilo_unit
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies use one shift-add step per cycle; divides use one restoring
// shift-subtract step per cycle. Signed operations work on magnitudes and
// fix up the signs in a single final cycle.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   start      operation request, sampled only while idle
//   op         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   cancel     pipeline flush; aborts an in-flight op, blocks an idle start
//   operand_a  rs value (multiplicand / dividend / MTHI-MTLO source)
//   operand_b  rt value (multiplier / divisor)
//   busy       high while a mul/div is in flight
//   done       one-cycle pulse after HI/LO are written by a mul/div
//   hi, lo     HI and LO registers
// ---------------------------------------------------------------------------
module mdu_hilo_unit #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              cancel,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int PW    = 2 * DATA_W;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Two's-complement negation of a data-width value.
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a full-width product.
  function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
    return ~v + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when treated as signed (sgn=1), v itself otherwise.
  // 0x80..0 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v,
                                              input logic sgn);
    return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  // Mul: {partial sum, remaining multiplier}. Div: {remainder, dividend/quotient}.
  logic [PW-1:0]     prod_q, prod_d;
  logic [DATA_W-1:0] opb_q, opb_d;          // |multiplicand| or |divisor|
  logic              sa_q, sa_d;            // operand_a was negative (signed ops)
  logic              sb_q, sb_d;            // operand_b was negative (signed ops)
  logic              is_div_q, is_div_d;
  logic              div_zero_q, div_zero_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   mul_sum_s;
  logic [DATA_W:0]   div_diff_s;
  logic [PW-1:0]     mul_step_s;
  logic [PW-1:0]     div_step_s;
  logic              is_signed_s;

  // One iteration step of the shift-add multiplier and restoring divider.
  always_comb begin
    // Carry out of the add becomes the top bit of the shifted product.
    mul_sum_s  = {1'b0, prod_q[PW-1:DATA_W]} + {1'b0, opb_q};
    mul_step_s = prod_q[0] ? {mul_sum_s, prod_q[DATA_W-1:1]}
                           : {1'b0, prod_q[PW-1:1]};
    // Shifted remainder needs DATA_W+1 bits; bit DATA_W of the difference is
    // the borrow because the partial remainder stays below the divisor.
    div_diff_s = prod_q[PW-1:DATA_W-1] - {1'b0, opb_q};
    div_step_s = div_diff_s[DATA_W]
               ? {prod_q[PW-2:0], 1'b0}
               : {div_diff_s[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b1};
    is_signed_s = ~op[0];
  end

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    prod_d     = prod_q;
    opb_d      = opb_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sa_d       = is_signed_s & operand_a[DATA_W-1];
              sb_d       = is_signed_s & operand_b[DATA_W-1];
              opb_d      = mag_w(operand_b, is_signed_s);
              prod_d     = {{DATA_W{1'b0}}, mag_w(operand_a, is_signed_s)};
              is_div_d   = op[1];
              div_zero_d = (operand_b == {DATA_W{1'b0}});
              counter_d  = {CNT_W{1'b0}};
              state_d    = op[1] ? S_DIV : S_MUL;
            end
            OP_MTHI: hi_d = operand_a;
            OP_MTLO: lo_d = operand_a;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          prod_d    = (state_q == S_DIV) ? div_step_s : mul_step_s;
          counter_d = counter_q + CNT_ONE;
          state_d   = (counter_q == CNT_LAST) ? S_FIX : state_q;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (cancel) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Remainder follows the dividend's sign; a zero divisor leaves the
            // remainder equal to the original dividend.
            hi_d = sa_q ? neg_w(prod_q[PW-1:DATA_W]) : prod_q[PW-1:DATA_W];
            if (div_zero_q) begin
              lo_d = {DATA_W{1'b1}};
            end else begin
              lo_d = (sa_q ^ sb_q) ? neg_w(prod_q[DATA_W-1:0])
                                   : prod_q[DATA_W-1:0];
            end
          end else begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? neg_p(prod_q) : prod_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      counter_q  <= {CNT_W{1'b0}};
      prod_q     <= {PW{1'b0}};
      opb_q      <= {DATA_W{1'b0}};
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {DATA_W{1'b0}};
      lo_q       <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      prod_q     <= prod_d;
      opb_q      <= opb_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_hilo_unit
// Directed self-checking bench for mdu_hilo_unit. Inputs change right after a
// rising edge or on a falling edge; outputs are sampled on falling edges.
// Consecutive mul/div ops are issued in the done cycle of the previous op.
// ---------------------------------------------------------------------------
module tb_mdu_hilo_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mdu_hilo_unit #(.DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .cancel(cancel),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a mul/div from a falling edge and observe 34 falling edges:
  // busy for the first 33, done only on the 34th (the done cycle).
  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    for (int i = 0; i < 34; i++) begin
      @(negedge CLK);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'd33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  // Single-edge MTHI/MTLO (optionally with cancel), leaving us on a falling edge.
  task automatic do_mt(input logic [2:0] o, input logic [31:0] a,
                       input logic c);
    op = o; operand_a = a; start = 1'b1; cancel = c;
    @(posedge CLK); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int done_seen;
    RST = 1'b1; start = 1'b0; op = 3'b000; cancel = 1'b0;
    operand_a = 32'h0; operand_b = 32'h0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);

    // Back-to-back chain: each op starts in the previous op's done cycle.
    do_op("mult_neg3x7", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("mult_zero", 3'b000, 32'h0, 32'h12345678, 32'h0, 32'h0);
    do_op("div_neg7by2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("divu_by0", 3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    do_op("div_neg_by0", 3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    do_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    do_op("divu_min_by3", 3'b011, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA);

    // Cancel an in-flight MULT; a start while busy must be ignored.
    op = 3'b000; operand_a = 32'd3; operand_b = 32'd5; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (4) @(negedge CLK);
    op = 3'b001; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (4) @(negedge CLK);
    check("cancel_busy_before", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(posedge CLK); #1 cancel = 1'b0;
    @(negedge CLK);
    check("cancel_busy_after", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (done || busy) done_seen++;
    end
    check("cancel_no_done", 32'(done_seen), 32'd0);
    check("cancel_hi_kept", hi, 32'd2);
    check("cancel_lo_kept", lo, 32'h2AAAAAAA);

    // start+cancel in IDLE with MTHI: no write.
    do_mt(3'b100, 32'hDEADBEEF, 1'b1);
    check("mthi_cancel_hi", hi, 32'd2);
    check("mthi_cancel_busy", {31'd0, busy}, 32'd0);

    do_mt(3'b100, 32'h00001234, 1'b0);
    check("mthi_hi", hi, 32'h00001234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_lo_kept", lo, 32'h2AAAAAAA);
    do_mt(3'b101, 32'h0000ABCD, 1'b0);
    check("mtlo_lo", lo, 32'h0000ABCD);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_hi_kept", hi, 32'h00001234);

    // Undefined op is ignored.
    do_mt(3'b111, 32'h55555555, 1'b0);
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h00001234);

    // Reset in the middle of a DIV.
    op = 3'b010; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (11) @(negedge CLK);
    check("div_busy_pre_reset", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);

    do_op("mult_6x7", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42);
    @(negedge CLK);
    check("done_drops", {31'd0, done}, 32'd0);
    check("final_lo_hold", lo, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
